uart_tx_buffered: RTL
=====================

// Module: uart_tx_buffered
// PURPOSE
//  Parametrised successor to the system's UART transmit path. Accepts result words from the ALU (or any
//  producer) as DATA_VALID pulses, buffers them in an internal FIFO and serialises them back-to-back.
//  Baud timing is generated internally from CLK by a programmable prescaler, so no divided clock is used.
//  Frame format: start, DATA_WD data bits LSB first, optional parity bit, then 1 or 2 stop bits.
// PARAMETERS
//  DATA_WD  8  payload bits per frame (>=5)
//  DEPTH    4  FIFO entries; power of 2, >=2
//  DIV_WD   8  width of DIV_RATIO
// PORTS
//  CLK         in   1           system clock
//  RST         in   1           synchronous reset, active-high
//  P_DATA      in   DATA_WD     word to transmit
//  DATA_VALID  in   1           push P_DATA this cycle
//  PAR_EN      in   1           1 = parity bit present
//  PAR_TYPE    in   1           0 = even, 1 = odd
//  STOP2       in   1           1 = two stop bits
//  DIV_RATIO   in   DIV_WD      CLK cycles per bit; 0 and 1 both mean 1
//  CLR_OVF     in   1           clears OVERFLOW
//  S_DATA      out  1           serial line, idle high
//  busy        out  1           frame in progress
//  FIFO_FULL   out  1           FIFO holds DEPTH words
//  FIFO_EMPTY  out  1           FIFO holds 0 words
//  LEVEL       out  log2(DEPTH)+1  words currently held
//  OVERFLOW    out  1           sticky: a push was dropped
// BEHAVIOUR
//  Reset values: S_DATA=1, busy=0, FIFO_EMPTY=1, FIFO_FULL=0, LEVEL=0, OVERFLOW=0, FSM=IDLE, prescaler=0.
//  Reset mid-frame aborts the frame; S_DATA returns high on the next edge and FIFO contents are discarded.
//  FIFO: push when DATA_VALID && !FIFO_FULL. Full/empty/LEVEL are registered.
//   - Push while full is dropped, even if a pop occurs in the same cycle; this sets OVERFLOW.
//   - Push and pop in the same cycle leave LEVEL unchanged.
//   - Pointers wrap modulo DEPTH.
//  OVERFLOW: set on a dropped push, cleared by CLR_OVF. Set wins if both happen in the same cycle.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE or START.
//   - IDLE: if !FIFO_EMPTY, pop the head into the shift register, latch PAR_EN/PAR_TYPE/STOP2/DIV_RATIO,
//     compute parity, and go to START. busy rises on the same edge.
//   - Configuration changes mid-frame take effect only at the next frame start.
//   - Each state holds for exactly N=max(DIV_RATIO,1) cycles. The prescaler restarts at 0 on entry to each
//     state and advances on count==N-1.
//   - DATA shifts out DATA_WD bits, LSB first, one per bit period.
//   - PARITY bit: ^data when PAR_TYPE=0, ~^data when PAR_TYPE=1. The state is skipped when PAR_EN=0.
//   - STOP2 state is entered only when latched STOP2=1.
//   - At the end of the last stop bit: if !FIFO_EMPTY, pop and go directly to START (no idle gap, busy stays
//     1); otherwise go to IDLE with busy=0.
//  S_DATA is registered and reflects the current state: START=0, DATA=shift[0], PARITY=bit, STOP/IDLE=1.
//  Latency: DATA_VALID sampled at edge k into an empty FIFO while IDLE -> pop at edge k+1 -> S_DATA=0 from
//   edge k+2.
//  Frame length: N*(1+DATA_WD+PAR_EN+1+STOP2) cycles.
// TESTING
//  T1: DATA_WD=8, DIV=4, PAR_EN=1, PAR_TYPE=0, STOP2=0; push 0xA5 -> S_DATA=0,1,0,1,0,0,1,0,1,0,1, each
//      held 4 cycles (44 total); busy=1 for those 44 cycles.
//  T2: Same word with PAR_TYPE=1, STOP2=1 -> parity bit=1, two stop bits, frame=48 cycles.
//  T3: DEPTH=4, DIV=2; push 6 words on consecutive cycles -> first 5 accepted (1 popped immediately +
//      4 buffered), 6th dropped, OVERFLOW=1. All 5 frames sent back-to-back with no idle gap; ends
//      FIFO_EMPTY=1.
//  T4: DIV_RATIO=0 -> each bit lasts 1 cycle. Push 0x00, PAR_EN=0 -> frame 0 x9 then 1; busy=1 for 10 cycles.
//  T5: Assert RST in the 3rd data bit of a frame with 2 words queued -> next edge S_DATA=1, busy=0, LEVEL=0,
//      and no further frames.
//  T6: CLR_OVF and a dropped push in the same cycle -> OVERFLOW stays 1; CLR_OVF alone next cycle -> 0.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered UART transmitter with FIFO, prescaler and configurable framing
//
// Accepts words as DATA_VALID pulses into a DEPTH-entry FIFO and serialises them
// back-to-back. Frame: start bit, DATA_WD data bits LSB first, optional parity bit,
// then one or two stop bits. Bit timing comes from a prescaler that runs on CLK.
//
// Ports:
//   CLK         system clock
//   RST         synchronous reset, active-high
//   P_DATA      word to transmit
//   DATA_VALID  push P_DATA this cycle (dropped if the FIFO is full)
//   PAR_EN      1 = parity bit present
//   PAR_TYPE    0 = even, 1 = odd
//   STOP2       1 = two stop bits
//   DIV_RATIO   CLK cycles per bit; 0 and 1 both mean 1
//   CLR_OVF     clears OVERFLOW (a simultaneous drop wins)
//   S_DATA      serial line, idle high
//   busy        frame in progress
//   FIFO_FULL   FIFO holds DEPTH words
//   FIFO_EMPTY  FIFO holds no words
//   LEVEL       number of words held
//   OVERFLOW    sticky: a push was dropped

module uart_tx_buffered #(
    parameter int DATA_WD = 8,
    parameter int DEPTH   = 4,
    parameter int DIV_WD  = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WD-1:0]       P_DATA,
    input  logic                     DATA_VALID,
    input  logic                     PAR_EN,
    input  logic                     PAR_TYPE,
    input  logic                     STOP2,
    input  logic [DIV_WD-1:0]        DIV_RATIO,
    input  logic                     CLR_OVF,
    output logic                     S_DATA,
    output logic                     busy,
    output logic                     FIFO_FULL,
    output logic                     FIFO_EMPTY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERFLOW
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(DATA_WD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_WD-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic [LW-1:0]      level_d;
    logic               full_q;
    logic               empty_q;
    logic               ovf_q;
    logic               ovf_d;

    logic               push;
    logic               drop;
    logic               pop;
    logic [DATA_WD-1:0] head;

    // A push against a full FIFO is dropped even when a pop frees a slot in the
    // same cycle, because fullness is judged on the registered flag.
    assign push = DATA_VALID && !full_q;
    assign drop = DATA_VALID && full_q;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Set beats clear when both happen in the same cycle.
        ovf_d = drop | (ovf_q & ~CLR_OVF);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= P_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            // Pointers are PW bits wide, so they wrap modulo DEPTH naturally.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            empty_q <= (level_d == '0);
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [DATA_WD-1:0] shift_q;
    logic               par_bit_q;
    logic               par_en_q;
    logic               stop2_q;
    logic [DIV_WD-1:0]  lim_q;       // last prescaler count of a bit period (N-1)
    logic [DIV_WD-1:0]  cnt_q;
    logic [BW-1:0]      bit_idx_q;
    logic               sdata_q;
    logic               busy_q;

    logic               bit_end;
    logic               frame_end;

    assign bit_end   = (cnt_q == lim_q);
    assign frame_end = bit_end &&
                       (((state_q == ST_STOP1) && !stop2_q) || (state_q == ST_STOP2));

    // Pop either from idle or at the very end of the last stop bit, which lets
    // queued words go out with no idle gap between frames.
    assign pop = !empty_q && ((state_q == ST_IDLE) || frame_end);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            lim_q     <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            sdata_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            // The line is a registered image of the current state, so it trails
            // the state by one cycle; every bit still lasts a full period.
            case (state_q)
                ST_START:  sdata_q <= 1'b0;
                ST_DATA:   sdata_q <= shift_q[0];
                ST_PARITY: sdata_q <= par_bit_q;
                default:   sdata_q <= 1'b1;
            endcase

            if (pop) begin
                // Configuration is sampled only here, so mid-frame changes wait
                // for the next frame.
                shift_q   <= head;
                par_bit_q <= (^head) ^ PAR_TYPE;
                par_en_q  <= PAR_EN;
                stop2_q   <= STOP2;
                lim_q     <= (DIV_RATIO == '0) ? '0 : DIV_RATIO - DIV_WD'(1);
                cnt_q     <= '0;
                bit_idx_q <= '0;
                state_q   <= ST_START;
                busy_q    <= 1'b1;
            end else if (state_q == ST_IDLE) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else if (bit_end) begin
                cnt_q <= '0;
                case (state_q)
                    ST_START: begin
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                    ST_DATA: begin
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + BW'(1);
                        if (bit_idx_q == BW'(DATA_WD - 1)) begin
                            state_q <= par_en_q ? ST_PARITY : ST_STOP1;
                        end
                    end
                    ST_PARITY: begin
                        state_q <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        if (stop2_q) begin
                            state_q <= ST_STOP2;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_STOP2: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else begin
                cnt_q <= cnt_q + DIV_WD'(1);
            end
        end
    end

    assign S_DATA     = sdata_q;
    assign busy       = busy_q;
    assign FIFO_FULL  = full_q;
    assign FIFO_EMPTY = empty_q;
    assign LEVEL      = level_q;
    assign OVERFLOW   = ovf_q;

endmodule
